// File: rtl/hash_table_lookup_pkg.sv
// Shared encodings for the exact-match lookup stage: FSM state bus and common constants.
package hash_table_lookup_pkg;

    localparam int LKUP_STATE_BUS = 3;

    localparam logic [LKUP_STATE_BUS-1:0] LKUP_STATE_IDLE = 3'd0;
    localparam logic [LKUP_STATE_BUS-1:0] LKUP_STATE_HASH = 3'd1;
    localparam logic [LKUP_STATE_BUS-1:0] LKUP_STATE_READ = 3'd2;
    localparam logic [LKUP_STATE_BUS-1:0] LKUP_STATE_CMP  = 3'd3;
    localparam logic [LKUP_STATE_BUS-1:0] LKUP_STATE_RESP = 3'd4;

    localparam logic        TRUE      = 1'b1;
    localparam logic        FALSE     = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0;

endpackage

// File: rtl/hash_table_lookup.sv
// Exact-match table lookup with linear probing: hashes the key, then reads up to MAX_PROBE slots.
// Latency 6 cycles accept->resp for a first-slot result, +2 per extra probe; holds the result until resp_ready_i.
module hash_table_lookup
    import hash_table_lookup_pkg::*;
#(
    parameter int KEY_W     = 64,
    parameter int DATA_W    = 32,
    parameter int INDEX_W   = 8,
    parameter int MAX_PROBE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [KEY_W-1:0]   key_i,
    output logic               hash_start_o,
    output logic [KEY_W-1:0]   hash_key_o,
    input  logic               hash_ready_i,
    input  logic [DATA_W-1:0]  hash_val_i,
    output logic               tbl_rd_o,
    output logic [INDEX_W-1:0] tbl_addr_o,
    input  logic               tbl_vld_i,
    input  logic [KEY_W-1:0]   tbl_key_i,
    input  logic [DATA_W-1:0]  tbl_data_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic               resp_hit_o,
    output logic [DATA_W-1:0]  resp_data_o,
    output logic [INDEX_W-1:0] resp_probes_o
);

    logic [LKUP_STATE_BUS-1:0] state;
    logic [KEY_W-1:0]          key_q;
    logic [INDEX_W-1:0]        index_q;
    // One bit wider than the address so a full-table probe limit still compares correctly.
    logic [INDEX_W:0]          probe_cnt;
    logic                      hash_first;

    logic [INDEX_W-1:0]        next_index;
    logic                      key_match;
    logic                      probe_limit;
    logic                      unused_hash_bits;

    assign next_index  = index_q + INDEX_W'(1);
    assign key_match   = tbl_vld_i && (tbl_key_i == key_q);
    assign probe_limit = (probe_cnt == (INDEX_W+1)'(MAX_PROBE));

    // Only the low hash bits address the table.
    assign unused_hash_bits = ^hash_val_i[DATA_W-1:INDEX_W];

    assign hash_key_o = key_q;
    assign tbl_addr_o = index_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LKUP_STATE_IDLE;
            key_q         <= '0;
            index_q       <= '0;
            probe_cnt     <= '0;
            hash_first    <= FALSE;
            req_ready_o   <= TRUE;
            hash_start_o  <= FALSE;
            tbl_rd_o      <= FALSE;
            resp_valid_o  <= FALSE;
            resp_hit_o    <= FALSE;
            resp_data_o   <= '0;
            resp_probes_o <= '0;
        end else begin
            case (state)
                LKUP_STATE_IDLE: begin
                    if (req_valid_i) begin
                        key_q        <= key_i;
                        probe_cnt    <= '0;
                        hash_first   <= TRUE;
                        hash_start_o <= TRUE;
                        req_ready_o  <= FALSE;
                        state        <= LKUP_STATE_HASH;
                    end
                end

                LKUP_STATE_HASH: begin
                    // hash_ready_i is sticky from the previous lookup during the first cycle here.
                    hash_first <= FALSE;
                    if (!hash_first && hash_ready_i) begin
                        index_q      <= hash_val_i[INDEX_W-1:0];
                        hash_start_o <= FALSE;
                        tbl_rd_o     <= TRUE;
                        state        <= LKUP_STATE_READ;
                    end
                end

                LKUP_STATE_READ: begin
                    tbl_rd_o  <= FALSE;
                    probe_cnt <= probe_cnt + (INDEX_W+1)'(1);
                    state     <= LKUP_STATE_CMP;
                end

                LKUP_STATE_CMP: begin
                    if (!tbl_vld_i || key_match || probe_limit) begin
                        resp_valid_o  <= TRUE;
                        resp_hit_o    <= key_match;
                        resp_data_o   <= key_match ? tbl_data_i : DATA_W'(ZERO_WORD);
                        resp_probes_o <= probe_cnt[INDEX_W-1:0];
                        state         <= LKUP_STATE_RESP;
                    end else begin
                        index_q  <= next_index;
                        tbl_rd_o <= TRUE;
                        state    <= LKUP_STATE_READ;
                    end
                end

                LKUP_STATE_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o  <= FALSE;
                        resp_hit_o    <= FALSE;
                        resp_data_o   <= '0;
                        resp_probes_o <= '0;
                        req_ready_o   <= TRUE;
                        state         <= LKUP_STATE_IDLE;
                    end
                end

                default: begin
                    state        <= LKUP_STATE_IDLE;
                    req_ready_o  <= TRUE;
                    hash_start_o <= FALSE;
                    tbl_rd_o     <= FALSE;
                    resp_valid_o <= FALSE;
                end
            endcase
        end
    end

endmodule
